// File: rtl/spart_pkg.sv
// spart_pkg: register map, status/ctrl bit positions and FSM state types shared by the SPART UART
package spart_pkg;
  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DIVL = 2'b10;
  localparam logic [1:0] ADDR_DIVH = 2'b11;
  localparam int ST_RDA = 0;
  localparam int ST_TBR = 1;
  localparam int ST_TX_IDLE = 2;
  localparam int ST_OVERRUN = 3;
  localparam int ST_FRAME_ERR = 4;
  localparam int ST_PARITY_ERR = 5;
  localparam int CTRL_PEN = 0;
  localparam int CTRL_PODD = 1;
  localparam int CTRL_TWO_STOP = 2;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
endpackage

// File: rtl/spart_fifo.sv
// spart_fifo: small synchronous FIFO; empty reads return zero, push on full is accepted only with a same-cycle pop
module spart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && (!full || pop);
  assign do_pop = pop && !empty;
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) mem[wp] <= din;
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/spart_fifo_uart.sv
// spart_fifo_uart: memory-mapped UART with TX/RX FIFOs, programmable divisor, parity and stop bits
module spart_fifo_uart
  import spart_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          TX_DEPTH   = 4,
  parameter int          RX_DEPTH   = 4,
  parameter int          OVERSAMPLE = 16,
  parameter logic [15:0] DIV_RST    = 16'd325
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] OS_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] OS_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_W - 1);
  logic rd, wr, stat_rd, tick;
  logic [2:0] ctrl;
  logic [15:0] div, bcnt;
  logic [7:0] div_lo, status, rx_dout, rx_din;
  logic overrun, frame_err, parity_err, tx_idle;
  assign rd = iocs & iorw;
  assign wr = iocs & ~iorw;
  assign stat_rd = rd && ioaddr == ADDR_STAT;
  assign tick = bcnt == '0;
  // A divisor-high write commits the full value and restarts the tick phase
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ctrl <= '0;
      div <= DIV_RST;
      div_lo <= '0;
      bcnt <= DIV_RST;
    end else begin
      if (wr && ioaddr == ADDR_STAT) ctrl <= data_in[2:0];
      if (wr && ioaddr == ADDR_DIVL) div_lo <= data_in;
      if (wr && ioaddr == ADDR_DIVH) div <= {data_in, div_lo};
      bcnt <= (wr && ioaddr == ADDR_DIVH) ? {data_in, div_lo} : tick ? div : bcnt - 16'd1;
    end
  logic tx_push, tx_pop, tx_full, tx_empty, tx_end, tx_last_stop;
  logic [DATA_W-1:0] tx_dout, tx_sh;
  tx_state_e tx_st;
  logic [CW-1:0] tx_cnt;
  logic [2:0] tx_bit;
  logic tx_par, tx_pen, tx_two, tx_stop2;
  assign tx_push = wr && ioaddr == ADDR_DATA;
  spart_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(data_in[DATA_W-1:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );
  assign tx_end = tick && tx_cnt == OS_LAST;
  assign tx_last_stop = tx_st == TX_STOP && tx_end && (!tx_two || tx_stop2);
  assign tx_pop = !tx_empty && ((tick && tx_st == TX_IDLE) || tx_last_stop);
  assign tx_idle = tx_st == TX_IDLE && tx_empty;
  // Frame settings are latched at the pop so ctrl writes only affect the next frame
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_st <= TX_IDLE;
      txd <= 1'b1;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
      tx_pen <= 1'b0;
      tx_two <= 1'b0;
      tx_stop2 <= 1'b0;
    end else if (tx_pop) begin
      tx_st <= TX_START;
      txd <= 1'b0;
      tx_cnt <= '0;
      tx_sh <= tx_dout;
      tx_par <= ^tx_dout ^ ctrl[CTRL_PODD];
      tx_pen <= ctrl[CTRL_PEN];
      tx_two <= ctrl[CTRL_TWO_STOP];
    end else if (tx_last_stop) begin
      tx_st <= TX_IDLE;
    end else if (tick && tx_st != TX_IDLE) begin
      tx_cnt <= tx_end ? '0 : tx_cnt + CW'(1);
      if (tx_end)
        case (tx_st)
          TX_START: begin
            tx_st <= TX_DATA;
            txd <= tx_sh[0];
            tx_bit <= '0;
          end
          TX_DATA: begin
            if (tx_bit == BIT_LAST) begin
              tx_st <= tx_pen ? TX_PARITY : TX_STOP;
              txd <= tx_pen ? tx_par : 1'b1;
              tx_stop2 <= 1'b0;
            end else begin
              tx_sh <= tx_sh >> 1;
              txd <= tx_sh[1];
              tx_bit <= tx_bit + 3'd1;
            end
          end
          TX_PARITY: begin
            tx_st <= TX_STOP;
            txd <= 1'b1;
            tx_stop2 <= 1'b0;
          end
          default: tx_stop2 <= 1'b1;
        endcase
    end
  logic rx_s1, rx_s2, rx_prev, rx_samp, rx_done, rx_push, rx_pop, rx_full, rx_empty, par_bad;
  rx_state_e rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0] rx_bit;
  logic [DATA_W-1:0] rx_sh;
  logic rx_pen, rx_odd;
  assign rx_samp = tick && rx_cnt == (rx_st == RX_START ? OS_HALF : OS_LAST);
  assign rx_done = rx_samp && rx_st == RX_STOP;
  assign rx_push = rx_done && !rx_full;
  assign rx_pop = rd && ioaddr == ADDR_DATA;
  assign rx_din = 8'(rx_sh);
  assign par_bad = rx_samp && rx_st == RX_PARITY && (rx_s2 != (^rx_sh ^ rx_odd));
  spart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_din),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );
  // Start-bit sample at half a bit rejects glitches; later samples land mid-bit
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_prev <= 1'b1;
      rx_st <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_pen <= 1'b0;
      rx_odd <= 1'b0;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_prev <= rx_s2;
      if (rx_st == RX_IDLE) begin
        if (rx_prev && !rx_s2) begin
          rx_st <= RX_START;
          rx_cnt <= '0;
          rx_pen <= ctrl[CTRL_PEN];
          rx_odd <= ctrl[CTRL_PODD];
        end
      end else if (tick) begin
        rx_cnt <= rx_samp ? '0 : rx_cnt + CW'(1);
        if (rx_samp)
          case (rx_st)
            RX_START: begin
              rx_st <= rx_s2 ? RX_IDLE : RX_DATA;
              rx_bit <= '0;
            end
            RX_DATA: begin
              rx_sh <= {rx_s2, rx_sh[DATA_W-1:1]};
              rx_bit <= rx_bit + 3'd1;
              if (rx_bit == BIT_LAST) rx_st <= rx_pen ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: rx_st <= RX_STOP;
            default: rx_st <= RX_IDLE;
          endcase
      end
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      overrun <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      overrun <= (overrun & ~stat_rd) | (rx_done & rx_full);
      frame_err <= (frame_err & ~stat_rd) | (rx_done & ~rx_s2);
      parity_err <= (parity_err & ~stat_rd) | par_bad;
    end
  assign rda = !rx_empty;
  assign tbr = !tx_full;
  always_comb begin
    status = '0;
    status[ST_RDA] = rda;
    status[ST_TBR] = tbr;
    status[ST_TX_IDLE] = tx_idle;
    status[ST_OVERRUN] = overrun;
    status[ST_FRAME_ERR] = frame_err;
    status[ST_PARITY_ERR] = parity_err;
  end
  assign data_out = !rd ? '0 : ioaddr == ADDR_DATA ? rx_dout : ioaddr == ADDR_STAT ? status :
                    ioaddr == ADDR_DIVL ? div[7:0] : div[15:8];
endmodule

// File: tb/tb_spart_fifo_uart.sv
// tb_spart_fifo_uart: scenario tasks with randomized bytes/ctrl checked against a frame-level UART model
module tb_spart_fifo_uart;
  import spart_pkg::*;
  localparam int BIT_CLK = 64;
  logic clk = 0, rst = 0, iocs = 0, iorw = 0, rx_drv = 1, loop = 0;
  logic [1:0] ioaddr = 0;
  logic [7:0] data_in = 0, data_out;
  logic rda, tbr, txd, rxd;
  int total = 0, passed = 0;
  logic exp_bits[$];
  assign rxd = loop ? txd : rx_drv;
  always #5 clk = ~clk;

  spart_fifo_uart dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .data_in(data_in),
    .data_out(data_out), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1; iorw = 0; ioaddr = a; data_in = d;
    @(negedge clk);
    iocs = 0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1; iorw = 1; ioaddr = a;
    #1 d = data_out;
    @(negedge clk);
    iocs = 0;
  endtask

  // Serial frame: start 0, data LSB first, optional parity, stop(s)
  function automatic void add_frame(input logic [7:0] d, input logic [2:0] c, input logic flip, input logic stop_v);
    exp_bits.push_back(1'b0);
    for (int b = 0; b < 8; b++) exp_bits.push_back(d[b]);
    if (c[0]) exp_bits.push_back(^d ^ c[1] ^ flip);
    exp_bits.push_back(stop_v);
    if (c[2]) exp_bits.push_back(1'b1);
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic [2:0] c, input logic flip, input logic stop_v);
    exp_bits.delete();
    add_frame(d, c, flip, stop_v);
    foreach (exp_bits[i]) begin
      rx_drv = exp_bits[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx_drv = 1;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic check_wave();
    int t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (txd !== 1'b0 && t < 600);
    total++;
    if (txd !== 1'b0) $display("FAIL tx_start: txd=%b expected 0 within 600 clk", txd);
    else passed++;
    for (int b = 0; b < exp_bits.size(); b++) begin
      int bad;
      bad = 0;
      for (int k = 0; k < BIT_CLK; k++) begin
        if (b != 0 || k != 0) begin
          @(posedge clk); #1;
        end
        if (txd !== exp_bits[b]) bad++;
      end
      total++;
      if (bad != 0) $display("FAIL tx_bit%0d: %0d of %0d clk differ, expected level %b", b, bad, BIT_CLK, exp_bits[b]);
      else passed++;
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({txd, rda, tbr, data_out} !== {1'b1, 1'b0, 1'b1, 8'h00})
      $display("FAIL reset_pins: txd/rda/tbr/data_out=%b%b%b/%h expected 101/00", txd, rda, tbr, data_out);
    else passed++;
    rst = 1;
    @(negedge clk);
    bus_read(ADDR_DIVL, v);
    total++;
    if (v !== 8'h45) $display("FAIL reset_divl: got %h expected 45", v); else passed++;
    bus_read(ADDR_DIVH, v);
    total++;
    if (v !== 8'h01) $display("FAIL reset_divh: got %h expected 01", v); else passed++;
    bus_read(ADDR_STAT, v);
    total++;
    if (v !== 8'h06) $display("FAIL reset_status: got %h expected 06", v); else passed++;
  endtask

  task automatic test_tx();
    logic [7:0] v, d0, d1;
    logic [2:0] c;
    bus_write(ADDR_DIVL, 8'h03);
    bus_write(ADDR_DIVH, 8'h00);
    bus_write(ADDR_STAT, 8'h00);
    exp_bits.delete();
    add_frame(8'hA5, 3'b000, 1'b0, 1'b1);
    fork
      bus_write(ADDR_DATA, 8'hA5);
      check_wave();
    join
    bus_read(ADDR_STAT, v);
    total++;
    if (v !== 8'h06) $display("FAIL tx_a5_idle_status: got %h expected 06", v); else passed++;
    for (int r = 0; r < 2; r++) begin
      c = 3'($urandom_range(0, 7));
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      bus_write(ADDR_STAT, {5'b0, c});
      exp_bits.delete();
      add_frame(d0, c, 1'b0, 1'b1);
      add_frame(d1, c, 1'b0, 1'b1);
      fork
        begin
          bus_write(ADDR_DATA, d0);
          bus_write(ADDR_DATA, d1);
        end
        check_wave();
      join
      bus_read(ADDR_STAT, v);
      total++;
      if (v !== 8'h06) $display("FAIL tx_b2b_status ctrl=%0d: got %h expected 06", c, v); else passed++;
    end
  endtask

  task automatic test_loopback();
    logic [7:0] v;
    logic [7:0] q[$];
    logic [2:0] c;
    int t;
    loop = 1;
    for (int r = 0; r < 2; r++) begin
      c = (r == 0) ? 3'b001 : 3'($urandom_range(0, 7));
      q.delete();
      if (r == 0) q = '{8'h3C, 8'hFF, 8'h00};
      else for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
      bus_write(ADDR_STAT, {5'b0, c});
      foreach (q[i]) bus_write(ADDR_DATA, q[i]);
      t = 0;
      while (rda !== 1'b1 && t < 2000) begin
        @(posedge clk); t++;
      end
      total++;
      if (rda !== 1'b1) $display("FAIL loop_rda ctrl=%0d: rda=%b expected 1 within 2000 clk", c, rda); else passed++;
      repeat (3 * (10 + c[0] + c[2]) * BIT_CLK) @(negedge clk);
      foreach (q[i]) begin
        bus_read(ADDR_DATA, v);
        total++;
        if (v !== q[i]) $display("FAIL loop_byte%0d ctrl=%0d: got %h expected %h", i, c, v, q[i]); else passed++;
      end
      bus_read(ADDR_STAT, v);
      total++;
      if (v !== 8'h06) $display("FAIL loop_status ctrl=%0d: got %h expected 06", c, v); else passed++;
    end
    loop = 0;
  endtask

  task automatic test_overrun();
    logic [7:0] v;
    logic [7:0] q[$];
    bus_write(ADDR_STAT, 8'h00);
    for (int i = 0; i < 5; i++) begin
      q.push_back(8'($urandom));
      send_frame(q[i], 3'b000, 1'b0, 1'b1);
    end
    bus_read(ADDR_STAT, v);
    total++;
    if (v !== 8'h0F) $display("FAIL overrun_status: got %h expected 0f", v); else passed++;
    for (int i = 0; i < 4; i++) begin
      bus_read(ADDR_DATA, v);
      total++;
      if (v !== q[i]) $display("FAIL overrun_byte%0d: got %h expected %h", i, v, q[i]); else passed++;
    end
    bus_read(ADDR_DATA, v);
    total++;
    if (v !== 8'h00) $display("FAIL empty_pop: got %h expected 00", v); else passed++;
    bus_read(ADDR_STAT, v);
    total++;
    if (v !== 8'h06) $display("FAIL overrun_cleared: got %h expected 06", v); else passed++;
  endtask

  task automatic test_errors();
    logic [7:0] v, d;
    for (int s = 0; s < 3; s++) begin
      logic [2:0] c;
      logic [7:0] exp_st;
      c = (s == 0) ? 3'b000 : 3'b011;
      exp_st = (s == 0) ? 8'h17 : (s == 1) ? 8'h27 : 8'h07;
      d = 8'($urandom);
      bus_write(ADDR_STAT, {5'b0, c});
      send_frame(d, c, s == 1, s != 0);
      bus_read(ADDR_STAT, v);
      total++;
      if (v !== exp_st) $display("FAIL err_status%0d: got %h expected %h", s, v, exp_st); else passed++;
      bus_read(ADDR_DATA, v);
      total++;
      if (v !== d) $display("FAIL err_byte%0d: got %h expected %h", s, v, d); else passed++;
    end
  endtask

  task automatic test_glitch();
    logic [7:0] v, d;
    bus_write(ADDR_STAT, 8'h00);
    rx_drv = 0;
    repeat (28) @(negedge clk);
    rx_drv = 1;
    repeat (3 * BIT_CLK) @(negedge clk);
    total++;
    if (rda !== 1'b0) $display("FAIL glitch_rda: got %b expected 0", rda); else passed++;
    bus_read(ADDR_STAT, v);
    total++;
    if (v !== 8'h06) $display("FAIL glitch_status: got %h expected 06", v); else passed++;
    d = 8'($urandom);
    send_frame(d, 3'b000, 1'b0, 1'b1);
    bus_read(ADDR_DATA, v);
    total++;
    if (v !== d) $display("FAIL post_glitch_byte: got %h expected %h", v, d); else passed++;
  endtask

  task automatic test_tx_full_reset();
    logic [7:0] v;
    logic [7:0] txq[$];
    int t;
    loop = 1;
    bus_write(ADDR_STAT, 8'h00);
    bus_write(ADDR_DIVL, 8'h00);
    bus_write(ADDR_DIVH, 8'h02);
    for (int i = 0; i < 5; i++) begin
      v = 8'($urandom);
      if (txq.size() < 4) txq.push_back(v);
      bus_write(ADDR_DATA, v);
      total++;
      if (tbr !== (txq.size() < 4)) $display("FAIL tbr_after_push%0d: got %b expected %b", i, tbr, txq.size() < 4);
      else passed++;
    end
    bus_write(ADDR_DIVL, 8'h03);
    bus_write(ADDR_DIVH, 8'h00);
    repeat (4 * 10 * BIT_CLK + 300) @(negedge clk);
    foreach (txq[i]) begin
      bus_read(ADDR_DATA, v);
      total++;
      if (v !== txq[i]) $display("FAIL txfull_byte%0d: got %h expected %h", i, v, txq[i]); else passed++;
    end
    bus_read(ADDR_DATA, v);
    total++;
    if (v !== 8'h00) $display("FAIL txfull_dropped: got %h expected 00", v); else passed++;
    bus_write(ADDR_DATA, 8'h55);
    t = 0;
    while (txd !== 1'b0 && t < 200) begin
      @(negedge clk); t++;
    end
    repeat (20) @(negedge clk);
    total++;
    if (txd !== 1'b0) $display("FAIL midframe_txd: got %b expected 0", txd); else passed++;
    #3 rst = 0;
    #1;
    total++;
    if ({txd, tbr, rda} !== 3'b110) $display("FAIL async_reset: txd/tbr/rda=%b%b%b expected 110", txd, tbr, rda);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1;
    bus_read(ADDR_DIVL, v);
    total++;
    if (v !== 8'h45) $display("FAIL rst_divl: got %h expected 45", v); else passed++;
    bus_read(ADDR_DIVH, v);
    total++;
    if (v !== 8'h01) $display("FAIL rst_divh: got %h expected 01", v); else passed++;
    repeat (200) @(negedge clk);
    bus_read(ADDR_STAT, v);
    total++;
    if (v !== 8'h06 || txd !== 1'b1) $display("FAIL rst_after: status=%h txd=%b expected 06/1", v, txd);
    else passed++;
    loop = 0;
  endtask

  initial begin
    test_reset();
    test_tx();
    test_loopback();
    test_overrun();
    test_errors();
    test_glitch();
    test_tx_full_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
